// File: rtl/pcie_msi_pkg.sv
// Shared types and helpers for the PCIe MSI interrupt controller.
package pcie_msi_pkg;

  localparam int unsigned MSI_MAX_VEC = 32;
  localparam int unsigned MSI_VEC_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_BACKOFF
  } msi_state_e;

  // Mask of usable vector bits for the granted vector count (capped at 32).
  function automatic logic [MSI_MAX_VEC-1:0] msi_alloc_mask(input logic [2:0] mmenable);
    logic [2:0] lg;
    lg = (mmenable > 3'd5) ? 3'd5 : mmenable;
    return (MSI_MAX_VEC'(1) << lg) - MSI_MAX_VEC'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 32,
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx_c,
  output logic               grant_valid_c
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] idx;
  logic             found;

  always_comb begin
    grant_valid_c = 1'b0;
    grant_idx_c   = '0;
    idx           = '0;
    found         = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + SUM_W'(k);
      if (idx >= SUM_W'(NUM_REQ)) idx = idx - SUM_W'(NUM_REQ);
      if (!found && req[idx[IDX_W-1:0]]) begin
        found       = 1'b1;
        grant_idx_c = idx[IDX_W-1:0];
      end
    end
    grant_valid_c = found;
  end

endmodule

// File: rtl/pcie_msi_irq_ctrl.sv
// Latches per-source interrupt requests and issues them one at a time as MSIs
// to the PCIe hard block (PF0), with fail/timeout back-off and retry.
module pcie_msi_irq_ctrl
  import pcie_msi_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 32,
  parameter int unsigned RETRY_DELAY = 64,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_IRQ-1:0]     irq_req,
  output logic                   irq_busy,
  output logic [NUM_IRQ-1:0]     irq_pending,
  input  logic [3:0]             cfg_interrupt_msi_enable,
  input  logic [11:0]            cfg_interrupt_msi_mmenable,
  output logic [31:0]            cfg_interrupt_msi_int,
  input  logic                   cfg_interrupt_msi_sent,
  input  logic                   cfg_interrupt_msi_fail,
  output logic [31:0]            cfg_interrupt_msi_pending_status,
  output logic                   cfg_interrupt_msi_pending_status_data_enable,
  output logic [3:0]             cfg_interrupt_msi_select,
  output logic [3:0]             cfg_interrupt_msi_pending_status_function_num,
  output logic [3:0]             cfg_interrupt_msi_function_number,
  output logic [2:0]             cfg_interrupt_msi_attr,
  output logic                   cfg_interrupt_msi_tph_present,
  output logic [1:0]             cfg_interrupt_msi_tph_type,
  output logic [8:0]             cfg_interrupt_msi_tph_st_tag,
  output logic [CNT_WIDTH-1:0]   sent_cnt,
  output logic [CNT_WIDTH-1:0]   fail_cnt
);

  localparam int unsigned IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int unsigned TMR_MAX = (TIMEOUT > RETRY_DELAY) ? TIMEOUT : RETRY_DELAY;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  msi_state_e               state_q, state_d;
  logic [NUM_IRQ-1:0]       pending_q, pending_d, clr_c;
  logic [IDX_W-1:0]         rr_ptr_q, cur_q, ptr_next_c, grant_idx_c;
  logic                     grant_valid_c;
  logic [TMR_W-1:0]         tmr_q;
  logic [31:0]              msi_int_q, ps_q, fold_c;
  logic                     ps_de_q, busy_q;
  logic [CNT_WIDTH-1:0]     sent_cnt_q, fail_cnt_q;
  logic [MSI_VEC_W-1:0]     vec_mask_c, grant_vec_c;
  logic                     take_c, sent_ack_c, fail_ack_c;
  logic                     unused_cfg;

  assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

  rr_arbiter #(.NUM_REQ(NUM_IRQ)) u_arb (
    .req          (pending_q),
    .ptr          (rr_ptr_q),
    .grant_idx_c  (grant_idx_c),
    .grant_valid_c(grant_valid_c)
  );

  assign vec_mask_c  = MSI_VEC_W'(msi_alloc_mask(cfg_interrupt_msi_mmenable[2:0]));
  assign grant_vec_c = MSI_VEC_W'(grant_idx_c) & vec_mask_c;
  assign ptr_next_c  = (cur_q == IDX_W'(NUM_IRQ - 1)) ? '0 : cur_q + IDX_W'(1);
  assign clr_c       = sent_ack_c ? (NUM_IRQ'(1) << cur_q) : '0;
  assign pending_d   = (pending_q & ~clr_c) | irq_req;

  // Pending sources folded onto the vectors the host actually allocated.
  always_comb begin
    fold_c = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (pending_q[i]) fold_c[MSI_VEC_W'(i) & vec_mask_c] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    take_c     = 1'b0;
    sent_ack_c = 1'b0;
    fail_ack_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_interrupt_msi_enable[0] && grant_valid_c) begin
          take_c  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // Sent takes priority when the IP reports both in the same cycle.
        if (cfg_interrupt_msi_sent) begin
          sent_ack_c = 1'b1;
          state_d    = ST_IDLE;
        end else if (cfg_interrupt_msi_fail || (tmr_q == TMR_W'(TIMEOUT - 1))) begin
          fail_ack_c = 1'b1;
          state_d    = ST_BACKOFF;
        end
      end
      ST_BACKOFF: begin
        if (tmr_q == TMR_W'(RETRY_DELAY - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      cur_q      <= '0;
      tmr_q      <= '0;
      msi_int_q  <= '0;
      ps_q       <= '0;
      ps_de_q    <= 1'b0;
      busy_q     <= 1'b0;
      sent_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      msi_int_q <= take_c ? (32'(1) << grant_vec_c) : '0;
      if (take_c) cur_q <= grant_idx_c;
      if (sent_ack_c || fail_ack_c) rr_ptr_q <= ptr_next_c;
      if (state_d != state_q) tmr_q <= '0;
      else if (state_q == ST_WAIT || state_q == ST_BACKOFF) tmr_q <= tmr_q + TMR_W'(1);
      ps_q    <= fold_c;
      ps_de_q <= (fold_c != ps_q);
      busy_q  <= (pending_d != '0) || (state_d != ST_IDLE);
      if (sent_ack_c && (sent_cnt_q != '1)) sent_cnt_q <= sent_cnt_q + CNT_WIDTH'(1);
      if (fail_ack_c && (fail_cnt_q != '1)) fail_cnt_q <= fail_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign irq_busy                                     = busy_q;
  assign irq_pending                                  = pending_q;
  assign cfg_interrupt_msi_int                        = msi_int_q;
  assign cfg_interrupt_msi_pending_status             = ps_q;
  assign cfg_interrupt_msi_pending_status_data_enable = ps_de_q;
  assign sent_cnt                                     = sent_cnt_q;
  assign fail_cnt                                     = fail_cnt_q;

  // PF0 only, no TPH.
  assign cfg_interrupt_msi_select                      = '0;
  assign cfg_interrupt_msi_pending_status_function_num = '0;
  assign cfg_interrupt_msi_function_number             = '0;
  assign cfg_interrupt_msi_attr                        = '0;
  assign cfg_interrupt_msi_tph_present                 = 1'b0;
  assign cfg_interrupt_msi_tph_type                    = '0;
  assign cfg_interrupt_msi_tph_st_tag                  = '0;

endmodule
